id_redirect: RTL and testbench
==============================

Name: id_redirect

Overview:
- Decode-side partner of the fetch stage. Holds the IF/ID pipeline register and resolves J, JAL, JR, BEQ and BNE from the latched instruction.
- Drives the fetch stage's redirect inputs (Jaddr, PC_branch, JAL, J, JR, Branch, PC_EN).
- Squashes the single wrong-path instruction fetched behind any taken redirect (no delay slot).
- All addresses are word indices, as the fetch PC is.

Parameters:
- CNT_W, 16, width of saturating redirect and stall performance counters.

Ports:
- clk  in  1  clock, rising edge.
- CLR_n  in  1  asynchronous active-low reset.
- IR_in  in  32  instruction from fetch stage.
- PC_in  in  32  word PC of IR_in.
- stall  in  1  hazard-unit hold request.
- rs_data  in  32  register-file read of IR_id[25:21].
- rt_data  in  32  register-file read of IR_id[20:16].
- IR_id  out  32  latched instruction.
- PC_id  out  32  latched PC.
- valid_id  out  1  IR_id is a real (non-squashed) instruction.
- link_addr  out  32  PC_id+1, return address for JAL.
- Jaddr  out  32  jump target, valid when JAL=1.
- PC_branch  out  32  branch target.
- JAL  out  1  select Jaddr at fetch; asserted for any taken jump (J, JAL, JR).
- J  out  1  qualifier: IR_id is J or JAL.
- JR  out  1  qualifier: IR_id is JR.
- Branch  out  1  taken BEQ/BNE.
- PC_EN  out  1  fetch PC enable.
- redirect_cnt  out  CNT_W  taken redirects, saturating.
- stall_cnt  out  CNT_W  stalled cycles, saturating.

Behaviour:
- Reset (CLR_n=0, asynchronous):
  - IR_id=0, PC_id=0, valid_id=0, state=BUBBLE.
  - Both counters 0.
  - Redirect outputs are therefore 0.
- Decode, gated by valid_id=1 and stall=0 (gate term g):
  - op=IR_id[31:26], funct=IR_id[5:0].
  - J: op=0x02. JAL: op=0x03. JR: op=0x00 and funct=0x08. BEQ: op=0x04. BNE: op=0x05.
- Targets (always computed; 32-bit wrap, no overflow detection):
  - link_addr = PC_id+1.
  - J/JAL target = {link_addr[31:26], IR_id[25:0]}.
  - JR target = rs_data. Jaddr muxes J/JAL target vs JR target.
  - PC_branch = PC_id + 1 + sign-extend(IR_id[15:0]).
- Redirect outputs (combinational, same cycle as decode; zero added latency):
  - J = g & (J|JAL). JR = g & JR. JAL = J | JR.
  - Branch = g & ((BEQ & rs_data==rt_data) | (BNE & rs_data!=rt_data)).
  - redirect = JAL | Branch.
- PC_EN = ~stall, independent of state. This holds the fetch PC together with the ID register.
- FSM, state reflected by valid_id:
  - States: RUN (valid_id=1) and BUBBLE (valid_id=0).
  - stall=1: hold IR_id/PC_id/state. stall_cnt++ (saturate). Redirect suppressed, since operands may be stale.
  - stall=0 and redirect=1: load IR_id=0, PC_id=PC_in, go to BUBBLE. redirect_cnt++ (saturate). This squashes the sequential instruction already fetched.
  - stall=0 and redirect=0: load IR_id=IR_in, PC_id=PC_in, go to RUN.
- Boundary cases:
  - Back-to-back redirects are impossible: a bubble always follows a redirect, and a bubble never redirects.
  - Stall and redirect condition in the same cycle: stall wins. The redirect fires in the first unstalled cycle.
  - Counters stop at all-ones and never wrap.
  - Reset mid-stall or mid-redirect: all state cleared immediately. The first edge after release latches IR_in as valid.
- An instruction of 0 (NOP) is never a redirect, in either state.

Test Plan:
- Reset then sequential fetch: IR_in=NOP, PC_in=0,1,2 -> PC_id follows one cycle later; valid_id 0 then 1; JAL=Branch=0; PC_EN=1.
- JAL 0x0000010 at PC_id=4 -> same cycle JAL=1, J=1, Jaddr=0x10, link_addr=5. Next edge: valid_id=0, IR_id=0. redirect_cnt=1.
- BEQ rs=rt with imm=0xFFFE at PC_id=8, rs_data=rt_data=7 -> Branch=1, PC_branch=7. Same BEQ with rt_data=6 -> Branch=0, next edge latches IR_in with valid_id=1.
- JR with rs_data=0x1F at PC_id=3 -> JAL=1, JR=1, J=0, Jaddr=0x1F; squash follows.
- BNE taken while stall=1 for 3 cycles -> Branch=0, PC_EN=0, IR_id held, stall_cnt=3. On stall release, Branch=1 that cycle.
- CNT_W=2, five taken redirects -> redirect_cnt saturates at 3. CLR_n pulsed low mid-stall -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_redirect.sv
// rtl/id_redirect.sv - IF/ID pipeline register with jump/branch resolution and wrong-path squash
module id_redirect #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             CLR_n,
    input  logic [31:0]      IR_in,
    input  logic [31:0]      PC_in,
    input  logic             stall,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [31:0]      IR_id,
    output logic [31:0]      PC_id,
    output logic             valid_id,
    output logic [31:0]      link_addr,
    output logic [31:0]      Jaddr,
    output logic [31:0]      PC_branch,
    output logic             JAL,
    output logic             J,
    output logic             JR,
    output logic             Branch,
    output logic             PC_EN,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {BUBBLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] ir_nxt, pc_nxt;
    logic [5:0]  op, funct;
    logic        is_j, is_jal, is_jr, is_beq, is_bne;
    logic        g, rs_eq, redirect;
    logic [31:0] j_target;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign op     = IR_id[31:26];
    assign funct  = IR_id[5:0];
    assign is_j   = (op == 6'h02);
    assign is_jal = (op == 6'h03);
    assign is_jr  = (op == 6'h00) && (funct == 6'h08);
    assign is_beq = (op == 6'h04);
    assign is_bne = (op == 6'h05);

    assign valid_id = (state == RUN);
    // Operands may be stale while the hazard unit holds us, so no redirect then.
    assign g        = valid_id && !stall;
    assign rs_eq    = (rs_data == rt_data);

    assign link_addr = PC_id + 32'd1;
    assign j_target  = {link_addr[31:26], IR_id[25:0]};
    assign Jaddr     = is_jr ? rs_data : j_target;
    assign PC_branch = PC_id + 32'd1 + {{16{IR_id[15]}}, IR_id[15:0]};

    assign J        = g && (is_j || is_jal);
    assign JR       = g && is_jr;
    assign JAL      = J || JR;
    assign Branch   = g && ((is_beq && rs_eq) || (is_bne && !rs_eq));
    assign redirect = JAL || Branch;
    assign PC_EN    = !stall;

    always_comb begin
        state_nxt = state;
        ir_nxt    = IR_id;
        pc_nxt    = PC_id;
        if (!stall) begin
            pc_nxt = PC_in;
            if (redirect) begin
                ir_nxt    = 32'd0;
                state_nxt = BUBBLE;
            end else begin
                ir_nxt    = IR_in;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            state        <= BUBBLE;
            IR_id        <= 32'd0;
            PC_id        <= 32'd0;
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            state <= state_nxt;
            IR_id <= ir_nxt;
            PC_id <= pc_nxt;
            if (stall && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (redirect && redirect_cnt != CNT_MAX)
                redirect_cnt <= redirect_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_redirect.sv
// tb/tb_id_redirect.sv - directed scoreboard bench for id_redirect
module tb_id_redirect;

    localparam int CNT_W = 2;
    localparam int S_IR = 0, S_PC = 1, S_VALID = 2, S_LINK = 3, S_JADDR = 4,
                   S_PCB = 5, S_FLAGS = 6, S_RCNT = 7, S_SCNT = 8;

    logic             clk = 1'b0;
    logic             CLR_n = 1'b0;
    logic [31:0]      IR_in = 32'd0, PC_in = 32'd0, rs_data = 32'd0, rt_data = 32'd0;
    logic             stall = 1'b0;
    logic [31:0]      IR_id, PC_id, link_addr, Jaddr, PC_branch;
    logic             valid_id, JAL, J, JR, Branch, PC_EN;
    logic [CNT_W-1:0] redirect_cnt, stall_cnt;

    string       qn[$];
    int          qs[$];
    logic [31:0] qe[$];
    int          vectors = 0;
    int          miscompares = 0;

    id_redirect #(.CNT_W(CNT_W)) dut (
        .clk(clk), .CLR_n(CLR_n), .IR_in(IR_in), .PC_in(PC_in), .stall(stall),
        .rs_data(rs_data), .rt_data(rt_data), .IR_id(IR_id), .PC_id(PC_id),
        .valid_id(valid_id), .link_addr(link_addr), .Jaddr(Jaddr), .PC_branch(PC_branch),
        .JAL(JAL), .J(J), .JR(JR), .Branch(Branch), .PC_EN(PC_EN),
        .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic ex(input string n, input int s, input logic [31:0] e);
        qn.push_back(n);
        qs.push_back(s);
        qe.push_back(e);
    endtask

    task automatic step(input logic [31:0] ir, input logic [31:0] pc, input logic st,
                        input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        IR_in   = ir;
        PC_in   = pc;
        stall   = st;
        rs_data = rs;
        rt_data = rt;
    endtask

    function automatic logic [31:0] probe(input int s);
        case (s)
            S_IR:    return IR_id;
            S_PC:    return PC_id;
            S_VALID: return {31'd0, valid_id};
            S_LINK:  return link_addr;
            S_JADDR: return Jaddr;
            S_PCB:   return PC_branch;
            S_FLAGS: return {27'd0, JAL, J, JR, Branch, PC_EN};
            S_RCNT:  return {{(32-CNT_W){1'b0}}, redirect_cnt};
            S_SCNT:  return {{(32-CNT_W){1'b0}}, stall_cnt};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: outputs are settled 2 time units after the stimulus edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (qn.size() > 0) begin
                string       n;
                int          s;
                logic [31:0] e, a;
                n = qn.pop_front();
                s = qs.pop_front();
                e = qe.pop_front();
                a = probe(s);
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", n, a, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] I_JAL = 32'h0C00_0010, I_BEQ = 32'h1000_FFFE,
                            I_JR  = 32'h03E0_0008, I_BNE = 32'h1400_0003,
                            I_J   = 32'h0800_0020, I_ADD = 32'h2000_0011;

    initial begin
        step(32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        ex("rst_ir", S_IR, 32'd0); ex("rst_pc", S_PC, 32'd0); ex("rst_valid", S_VALID, 0);
        ex("rst_flags", S_FLAGS, 32'h01); ex("rst_rcnt", S_RCNT, 0); ex("rst_scnt", S_SCNT, 0);
        ex("rst_jaddr", S_JADDR, 32'd0);

        step(32'd0, 32'd0, 1'b0, 32'd0, 32'd0); CLR_n = 1'b1;
        ex("rel_valid", S_VALID, 0);
        step(32'd0, 32'd1, 1'b0, 32'd0, 32'd0);
        ex("seq0_pc", S_PC, 32'd0); ex("seq0_valid", S_VALID, 1); ex("seq0_link", S_LINK, 32'd1);
        step(32'd0, 32'd2, 1'b0, 32'd0, 32'd0);
        ex("seq1_pc", S_PC, 32'd1); ex("seq1_flags", S_FLAGS, 32'h01);
        step(I_JAL, 32'd4, 1'b0, 32'd0, 32'd0);
        ex("seq2_pc", S_PC, 32'd2);

        step(I_ADD, 32'd5, 1'b0, 32'd0, 32'd0);
        ex("jal_flags", S_FLAGS, 32'h19); ex("jal_jaddr", S_JADDR, 32'h10);
        ex("jal_link", S_LINK, 32'd5); ex("jal_rcnt", S_RCNT, 0);
        step(I_BEQ, 32'd8, 1'b0, 32'd7, 32'd7);
        ex("jal_sq_ir", S_IR, 32'd0); ex("jal_sq_valid", S_VALID, 0);
        ex("jal_sq_pc", S_PC, 32'd5); ex("jal_sq_rcnt", S_RCNT, 1); ex("bubble_flags", S_FLAGS, 32'h01);

        step(I_ADD, 32'd9, 1'b0, 32'd7, 32'd7);
        ex("beq_flags", S_FLAGS, 32'h03); ex("beq_pcb", S_PCB, 32'd7); ex("beq_valid", S_VALID, 1);
        step(I_BEQ, 32'd8, 1'b0, 32'd7, 32'd6);
        ex("beq_sq_ir", S_IR, 32'd0); ex("beq_sq_valid", S_VALID, 0);
        ex("beq_sq_pc", S_PC, 32'd9); ex("beq_sq_rcnt", S_RCNT, 2);
        step(I_ADD, 32'd9, 1'b0, 32'd7, 32'd6);
        ex("beqnt_flags", S_FLAGS, 32'h01); ex("beqnt_pcb", S_PCB, 32'd7); ex("beqnt_ir", S_IR, I_BEQ);
        step(I_JR, 32'd3, 1'b0, 32'd0, 32'd0);
        ex("beqnt_next_ir", S_IR, I_ADD); ex("beqnt_next_valid", S_VALID, 1);
        ex("beqnt_next_pc", S_PC, 32'd9); ex("add_flags", S_FLAGS, 32'h01);

        step(I_ADD, 32'd4, 1'b0, 32'h1F, 32'd0);
        ex("jr_flags", S_FLAGS, 32'h15); ex("jr_jaddr", S_JADDR, 32'h1F);
        step(I_BNE, 32'd10, 1'b0, 32'd1, 32'd2);
        ex("jr_sq_ir", S_IR, 32'd0); ex("jr_sq_valid", S_VALID, 0); ex("jr_sq_rcnt", S_RCNT, 3);

        step(I_ADD, 32'd11, 1'b1, 32'd1, 32'd2);
        ex("st1_flags", S_FLAGS, 32'h00); ex("st1_ir", S_IR, I_BNE); ex("st1_scnt", S_SCNT, 0);
        step(I_ADD, 32'd11, 1'b1, 32'd1, 32'd2);
        ex("st2_ir", S_IR, I_BNE); ex("st2_pc", S_PC, 32'd10); ex("st2_scnt", S_SCNT, 1);
        step(I_ADD, 32'd11, 1'b1, 32'd1, 32'd2);
        ex("st3_flags", S_FLAGS, 32'h00); ex("st3_scnt", S_SCNT, 2);
        step(I_ADD, 32'd11, 1'b0, 32'd1, 32'd2);
        ex("bne_flags", S_FLAGS, 32'h03); ex("bne_pcb", S_PCB, 32'd14);
        ex("bne_scnt", S_SCNT, 3); ex("bne_ir", S_IR, I_BNE);
        step(I_J, 32'h0BFF_FFFF, 1'b0, 32'd0, 32'd0);
        ex("bne_sq_valid", S_VALID, 0); ex("rcnt_sat4", S_RCNT, 3); ex("bne_sq_pc", S_PC, 32'd11);

        step(I_ADD, 32'd13, 1'b0, 32'd0, 32'd0);
        ex("j_flags", S_FLAGS, 32'h19); ex("j_link", S_LINK, 32'h0C00_0000);
        ex("j_jaddr", S_JADDR, 32'h0C00_0020);
        step(I_ADD, 32'd14, 1'b1, 32'd0, 32'd0);
        ex("rcnt_sat5", S_RCNT, 3); ex("stb_valid", S_VALID, 0);
        ex("stb_flags", S_FLAGS, 32'h00); ex("stb_scnt", S_SCNT, 3);
        step(I_ADD, 32'd14, 1'b1, 32'd0, 32'd0);
        ex("scnt_sat", S_SCNT, 3); ex("stb_pc", S_PC, 32'd13);

        step(I_ADD, 32'd14, 1'b1, 32'd0, 32'd0);
        #1 CLR_n = 1'b0;
        ex("arst_ir", S_IR, 32'd0); ex("arst_pc", S_PC, 32'd0); ex("arst_valid", S_VALID, 0);
        ex("arst_rcnt", S_RCNT, 0); ex("arst_scnt", S_SCNT, 0); ex("arst_flags", S_FLAGS, 32'h00);
        step(I_ADD, 32'd20, 1'b0, 32'd0, 32'd0); CLR_n = 1'b1;
        ex("arel_valid", S_VALID, 0);
        step(32'd0, 32'd21, 1'b0, 32'd0, 32'd0);
        ex("arel_ir", S_IR, I_ADD); ex("arel_pc", S_PC, 32'd20); ex("arel_valid1", S_VALID, 1);

        @(negedge clk);
        #4;
        if (qn.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", qn.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
